mprj_capture_fifo: RTL and testbench

Downstream consumer of the user-project GPIO control stage. It watches the registered mprj_o bus produced by that stage and detects every value change. Each change is stored as a {timestamp, value} record in a small FIFO, and a valid/ready port drains the records. The block gives firmware and test logic a lossless, time-tagged trace of GPIO output activity.

---
 rtl/mprj_capture_fifo.sv | 121 ++++++++++++
 tb/tb_mprj_capture_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_capture_fifo.sv
// mprj_capture_fifo
//
// Watches the registered mprj_o bus from the GPIO control stage. Every value
// change is stored as a {timestamp, value} record in a small FIFO. A
// valid/ready port drains the records.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   mprj_o_in   bus under observation (GPIO_SIZE bits)
//   capture_en  1 = change detection armed
//   clear       synchronous flush of FIFO, flags, counters and timestamp
//   out_valid   head record available
//   out_ready   consumer accepts head record
//   out_data    {timestamp, value}, timestamp in the MSBs
//   level       current entry count, 0..DEPTH
//   overflow    sticky: a change was dropped because the FIFO was full
//   drop_cnt    saturating count of dropped changes
module mprj_capture_fifo #(
  parameter int unsigned GPIO_SIZE = 38,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TS_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [GPIO_SIZE-1:0]      mprj_o_in,
  input  logic                      capture_en,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TS_W+GPIO_SIZE-1:0] out_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [15:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned RW = TS_W + GPIO_SIZE;

  logic [GPIO_SIZE-1:0] s0_q, s1_q;
  logic [TS_W-1:0]      ts_q, ts_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic [RW-1:0]        mem_q [DEPTH];

  logic chg, full, empty, push, pop, drop;

  always_comb begin
    chg   = capture_en && (s0_q != s1_q);
    full  = (level_q == LW'(DEPTH));
    empty = (level_q == '0);
    // clear wins over any transfer on the same edge
    pop   = !empty && out_ready && !clear;
    // a pop frees the slot that a push into a full FIFO needs
    push  = chg && !clear && (!full || pop);
    drop  = chg && !clear && full && !pop;

    ts_d       = ts_q + TS_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (clear) begin
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q       <= '0;
      s1_q       <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      s0_q       <= mprj_o_in;
      s1_q       <= s0_q;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= {ts_q, s0_q};
  end

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mprj_capture_fifo.sv
module tb_mprj_capture_fifo;

  localparam int unsigned GPIO_SIZE = 38;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned TS_W      = 16;
  localparam int unsigned RW        = TS_W + GPIO_SIZE;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [GPIO_SIZE-1:0]   mprj_o_in = '0;
  logic                   capture_en = 1'b1;
  logic                   clear = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [RW-1:0]          out_data;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic [15:0]            drop_cnt;

  mprj_capture_fifo #(
    .GPIO_SIZE(GPIO_SIZE),
    .DEPTH    (DEPTH),
    .TS_W     (TS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mprj_o_in (mprj_o_in),
    .capture_en(capture_en),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: a queue of records plus sampled-bus history.
  logic [RW-1:0]        mq[$];
  logic [GPIO_SIZE-1:0] m_s0 = '0, m_s1 = '0;
  logic [TS_W-1:0]      m_ts = '0;
  bit                   m_ovf = 1'b0;
  int                   m_drop = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_s0 = '0; m_s1 = '0; m_ts = '0; m_ovf = 1'b0; m_drop = 0;
    end else begin
      bit change, take;
      change = capture_en && (m_s0 != m_s1);
      take   = (mq.size() != 0) && out_ready;
      if (clear) begin
        mq.delete();
        m_ovf = 1'b0;
        m_drop = 0;
      end else begin
        if (take) void'(mq.pop_front());
        if (change) begin
          if (mq.size() < DEPTH) mq.push_back({m_ts, m_s0});
          else begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      m_ts = clear ? '0 : m_ts + 1'b1;
      m_s1 = m_s0;
      m_s0 = mprj_o_in;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("level", 64'(level), 64'(mq.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (mq.size() != 0) check("out_data", 64'(out_data), 64'(mq[0]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    chk_on = 1'b1;
  endtask

  initial begin
    // 1: held value right after reset gives exactly one record with ts=1
    mprj_o_in = 38'h1234;
    capture_en = 1'b1;
    do_reset();
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    step(1);
    check("t1_not_yet", 64'(out_valid), 64'd0);
    step(1);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_data", 64'(out_data), 64'({16'd1, 38'h1234}));
    step(5);
    check("t1_single", 64'(level), 64'd1);

    // 2: three consecutive changes, then drain in order
    mprj_o_in = '0;
    do_reset();
    mprj_o_in = 38'h1; step(1);
    mprj_o_in = 38'h3; step(1);
    mprj_o_in = 38'h7; step(1);
    step(2);
    check("t2_level", 64'(level), 64'd3);
    check("t2_head", 64'(out_data), 64'({16'd1, 38'h1}));
    out_ready = 1'b1; step(1);
    check("t2_second", 64'(out_data), 64'({16'd2, 38'h3}));
    step(4);
    out_ready = 1'b0;
    check("t2_empty", 64'(level), 64'd0);

    // 3: DEPTH+5 changes into a stalled FIFO
    mprj_o_in = '0;
    do_reset();
    for (int i = 0; i < DEPTH + 5; i++) begin
      mprj_o_in = GPIO_SIZE'(i + 1);
      step(1);
    end
    step(2);
    check("t3_level", 64'(level), 64'd16);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_drop", 64'(drop_cnt), 64'd5);
    check("t3_head", 64'(out_data), 64'({16'd1, 38'd1}));

    // 4: change and pop on the same edge at full
    mprj_o_in = 38'd99; step(1);
    out_ready = 1'b1; step(1);
    out_ready = 1'b0;
    check("t4_level", 64'(level), 64'd16);
    check("t4_drop", 64'(drop_cnt), 64'd5);
    out_ready = 1'b1; step(15);
    out_ready = 1'b0;
    check("t4_tail", 64'(out_data[GPIO_SIZE-1:0]), 64'd99);
    out_ready = 1'b1; step(2);
    out_ready = 1'b0;
    check("t4_empty", 64'(level), 64'd0);

    // 5: toggles while disarmed are not recorded or replayed
    mprj_o_in = '0;
    do_reset();
    capture_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mprj_o_in = GPIO_SIZE'(i + 5);
      step(1);
    end
    step(3);
    capture_en = 1'b1;
    step(5);
    check("t5_none", 64'(level), 64'd0);
    mprj_o_in = 38'h2A; step(3);
    check("t5_one", 64'(level), 64'd1);
    check("t5_val", 64'(out_data[GPIO_SIZE-1:0]), 64'h2A);

    // 6: clear mid-stream with a simultaneous change, then ts wrap
    mprj_o_in = '0;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      mprj_o_in = GPIO_SIZE'(i + 100);
      step(1);
    end
    step(2);
    out_ready = 1'b1; step(9);
    out_ready = 1'b0;
    check("t6_level7", 64'(level), 64'd7);
    check("t6_ovf_set", 64'(overflow), 64'd1);
    mprj_o_in = 38'h3FF; step(1);
    clear = 1'b1; step(1);
    clear = 1'b0;
    check("t6_clr_level", 64'(level), 64'd0);
    check("t6_clr_ovf", 64'(overflow), 64'd0);
    check("t6_clr_drop", 64'(drop_cnt), 64'd0);
    mprj_o_in = 38'h155; step(2);
    check("t6_after", 64'(out_data), 64'({16'd1, 38'h155}));
    out_ready = 1'b1; step(1);
    out_ready = 1'b0;
    clear = 1'b1; step(1);
    clear = 1'b0;
    step(65535);
    mprj_o_in = 38'hABC; step(2);
    check("t6_wrap", 64'(out_data), 64'({16'd0, 38'hABC}));

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) != 0)
        mprj_o_in = ($urandom_range(0, 1) == 0) ? GPIO_SIZE'($urandom_range(0, 3))
                                                : GPIO_SIZE'({$urandom(), $urandom()});
      out_ready  = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      capture_en = ($urandom_range(0, 7) != 0);
      clear      = ($urandom_range(0, 63) == 0);
      step(1);
    end
    clear = 1'b0;
    out_ready = 1'b1;
    step(DEPTH + 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
